sram_controller: RTL and testbench

- Replaces the single-cycle register-array data memory in the MEM stage.
- Takes the same load/store request the EXE/MEM register already produces: read enable, write enable, 32-bit byte address and 32-bit store data.
- Serves each request from an external 16-bit asynchronous SRAM, using two half-word accesses with programmable wait states.
- Drives `ready` low to freeze the pipeline while an access is in flight, and returns the registered 32-bit load data to the MEM/WB register.

---
 rtl/sram_pkg.sv | 21 ++
 rtl/sram_wait_counter.sv | 21 ++
 rtl/sram_controller.sv | 127 ++++++++++++
 tb/tb_sram_controller.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and helpers for the 16-bit asynchronous SRAM data-memory controller.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int unsigned WAIT_STATES_DEF = 5;
  localparam int unsigned ADDR_BASE_DEF   = 1024;

  // Word offset from the start of the SRAM window; callers truncate as needed.
  function automatic logic [29:0] word_index(input logic [31:0] address, input logic [31:0] base);
    logic [31:0] off;
    off = address - base;
    return off[31:2];
  endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait-state counter: loads WAIT_STATES-1 on phase entry, flags the final cycle.
module sram_wait_counter #(
  parameter int unsigned WAIT_STATES = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic last_cycle
);

  logic [3:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= 4'(WAIT_STATES - 1);
    else if (cnt != '0)   cnt <= cnt - 4'd1;
  end

  assign last_cycle = (cnt == '0);

endmodule

// File: rtl/sram_controller.sv
// MEM-stage data memory backed by a 16-bit async SRAM: two half-word phases per word access.
// Optional SRAM_RANGE_CHECK_EN adds addr_err and short-circuits out-of-window requests.
module sram_controller
  import sram_pkg::*;
#(
  parameter int unsigned WAIT_STATES = WAIT_STATES_DEF,
  parameter int unsigned ADDR_BASE   = ADDR_BASE_DEF,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  inout  wire  [15:0]        sram_dq,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic               sram_ce_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
`ifdef SRAM_RANGE_CHECK_EN
  ,
  output logic               addr_err
`endif
);

  state_t             state, state_nxt;
  logic               req, err_req, load, last_cycle, in_phase, drive;
  logic               is_wr_q;
  logic [SRAM_AW-2:0] idx_q, idx_trunc;
  logic [31:0]        wdata_q;
  logic [15:0]        shadow_lo, wr_half;

  assign req = rd_en | wr_en;

`ifdef SRAM_RANGE_CHECK_EN
  logic [29:0] idx_full;
  logic        err_q;

  assign idx_full  = word_index(address, 32'(ADDR_BASE));
  assign idx_trunc = idx_full[SRAM_AW-2:0];
  assign err_req   = (address < 32'(ADDR_BASE)) || (address[1:0] != 2'b00) ||
                     ((idx_full >> (SRAM_AW - 1)) != '0);
  assign addr_err  = (state == DONE) && err_q;
`else
  assign idx_trunc = (SRAM_AW-1)'(word_index(address, 32'(ADDR_BASE)));
  assign err_req   = 1'b0;
`endif

  sram_wait_counter #(.WAIT_STATES(WAIT_STATES)) u_wait (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .last_cycle (last_cycle)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: if (req) begin
        if (err_req) state_nxt = DONE;
        else begin
          state_nxt = LOW;
          load      = 1'b1;
        end
      end
      LOW:  if (last_cycle) begin
        state_nxt = HIGH;
        load      = 1'b1;
      end
      HIGH: if (last_cycle) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      is_wr_q   <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      shadow_lo <= '0;
      read_data <= '0;
`ifdef SRAM_RANGE_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && req) begin
        is_wr_q <= wr_en;
        idx_q   <= idx_trunc;
        wdata_q <= write_data;
`ifdef SRAM_RANGE_CHECK_EN
        err_q   <= err_req;
        if (err_req && !wr_en) read_data <= '0;
`endif
      end
      if (state == LOW && last_cycle && !is_wr_q)
        shadow_lo <= sram_dq;
      // Upper half is taken straight off the bus so the word is complete in DONE.
      if (state == HIGH && last_cycle && !is_wr_q)
        read_data <= {sram_dq, shadow_lo};
    end
  end

  assign in_phase  = (state == LOW) || (state == HIGH);
  assign sram_ce_n = !in_phase;
  assign sram_ub_n = !in_phase;
  assign sram_lb_n = !in_phase;
  assign sram_oe_n = !(in_phase && !is_wr_q);
  // we_n releases one cycle early so data still holds across the rising edge.
  assign sram_we_n = !(in_phase && is_wr_q && (!last_cycle || WAIT_STATES == 1));
  assign sram_addr = in_phase ? {idx_q, state == HIGH} : '0;

  assign drive   = in_phase && is_wr_q;
  assign wr_half = (state == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
  assign sram_dq = drive ? wr_half : 16'bz;

  assign ready = !req || (state == DONE);

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller with a behavioural async-SRAM and word-level memory model.
module tb_sram_controller;

  localparam int WS   = 5;
  localparam int AW   = 18;
  localparam int BASE = 1024;

  logic          clk, rst, wr_en, rd_en;
  logic [31:0]   address, write_data, read_data;
  logic          ready, we_n, oe_n, ce_n, ub_n, lb_n;
  logic [AW-1:0] sram_addr;
  wire  [15:0]   sram_dq;
`ifdef SRAM_RANGE_CHECK_EN
  logic          addr_err;
`endif

  sram_controller #(.WAIT_STATES(WS), .ADDR_BASE(BASE), .SRAM_AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready), .sram_dq(sram_dq),
    .sram_addr(sram_addr), .sram_we_n(we_n), .sram_oe_n(oe_n), .sram_ce_n(ce_n),
    .sram_ub_n(ub_n), .sram_lb_n(lb_n)
`ifdef SRAM_RANGE_CHECK_EN
    , .addr_err(addr_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural asynchronous SRAM
  logic [15:0] sram_mem [0:(1<<AW)-1];
  logic        sram_rd;
  assign sram_rd = !ce_n && !oe_n && we_n;
  assign sram_dq = sram_rd ? sram_mem[sram_addr] : 16'bz;
  always @(negedge clk)
    if (!ce_n && !we_n) sram_mem[sram_addr] <= sram_dq;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Word-level reference model
  typedef struct {
    bit          wr;
    bit          err;
    int          idx;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ref_mem [int];
  logic [31:0] last_read = '0;

  task automatic issue(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   guard = 0;
    e.err = 1'b0;
`ifdef SRAM_RANGE_CHECK_EN
    e.err = (a < BASE) || (a % 4 != 0) || (((a - BASE) / 4) >= (1 << (AW - 1)));
`endif
    e.idx   = int'((a - BASE) / 4);
    e.wr    = w;
    e.wdata = d;
    if (w) begin
      if (!e.err) ref_mem[e.idx] = d;
      e.rdata = last_read;
    end else begin
      e.rdata   = e.err ? 32'h0 : ref_mem[e.idx];
      last_read = e.rdata;
    end
    q.push_back(e);
    wr_en = w; rd_en = r; address = a; write_data = d;
    do begin
      @(negedge clk);
      guard++;
    end while (!ready && guard < 200);
    if (!ready) begin
      n_chk++; n_fail++;
      $display("FAIL ready_timeout: got 0 expected 1");
    end
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  // Monitor: tallies bus activity per request and checks it when ready completes the request.
  int stall_c, ce_c, lo_c, hi_c, we_c, oe_c, be_c, aerr_c;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      {stall_c, ce_c, lo_c, hi_c, we_c, oe_c, be_c, aerr_c} = '0;
    end else if ((wr_en | rd_en) && q.size() > 0) begin
      e = q[0];
      if (!ce_n) begin
        ce_c++;
        if (ub_n || lb_n) be_c++;
        if (sram_addr == AW'(2 * e.idx) && (!e.wr || sram_dq == e.wdata[15:0])) lo_c++;
        if (sram_addr == AW'(2 * e.idx + 1) && (!e.wr || sram_dq == e.wdata[31:16])) hi_c++;
      end
      if (!we_n) we_c++;
      if (!oe_n) oe_c++;
`ifdef SRAM_RANGE_CHECK_EN
      if (addr_err) aerr_c++;
`endif
      if (!ready) stall_c++;
      else begin
        void'(q.pop_front());
        chk("stall_cycles", stall_c, e.err ? 1 : 2 * WS + 1);
        chk("ce_cycles", ce_c, e.err ? 0 : 2 * WS);
        chk("low_phase", lo_c, e.err ? 0 : WS);
        chk("high_phase", hi_c, e.err ? 0 : WS);
        chk("we_cycles", we_c, (e.wr && !e.err) ? 2 * (WS > 1 ? WS - 1 : 1) : 0);
        chk("oe_cycles", oe_c, (!e.wr && !e.err) ? 2 * WS : 0);
        chk("byte_enables", be_c, 0);
        chk("read_data", read_data, e.rdata);
`ifdef SRAM_RANGE_CHECK_EN
        chk("addr_err_cycles", aerr_c, e.err ? 1 : 0);
`endif
        {stall_c, ce_c, lo_c, hi_c, we_c, oe_c, be_c, aerr_c} = '0;
      end
    end
  end

  initial begin
    logic [31:0] v;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      ref_mem[i] = v;
      sram_mem[2 * i]     = v[15:0];
      sram_mem[2 * i + 1] = v[31:16];
    end
    repeat (2) @(negedge clk);
    chk("reset_ready", ready, 1);
    chk("reset_strobes", {ce_n, we_n, oe_n, ub_n, lb_n}, 5'b11111);
    chk("reset_addr", sram_addr, 0);
    chk("reset_read_data", read_data, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed scenarios
    issue(1, 0, 32'd1024, 32'hDEADBEEF);
    issue(0, 1, 32'd1024, 32'h0);
    issue(1, 0, 32'd1028, 32'h12345678);
    issue(0, 1, 32'd1028, 32'h0);
    issue(1, 1, 32'd1032, 32'h0000CAFE);
    issue(0, 1, 32'd1032, 32'h0);

    // Reset in the middle of the HIGH phase of a store
    wr_en = 1'b1; address = BASE + 4 * 100; write_data = 32'hA5A5_5A5A;
    repeat (WS + 3) @(posedge clk);
    #1 rst = 1'b1; wr_en = 1'b0;
    #1;
    chk("abort_strobes", {ce_n, we_n, oe_n, ub_n, lb_n}, 5'b11111);
    chk("abort_ready", ready, 1);
    chk("abort_addr", sram_addr, 0);
    chk("abort_read_data", read_data, 0);
    last_read = '0;
    ref_mem.delete(100);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    issue(0, 1, 32'd1028, 32'h0);

`ifdef SRAM_RANGE_CHECK_EN
    issue(0, 1, 32'd512, 32'h0);
    issue(1, 0, 32'd1026, 32'h1111_2222);
    issue(0, 1, 32'd1024, 32'h0);
`endif

    // Randomized traffic inside the preloaded window
    for (int n = 0; n < 40; n++) begin
      int op, idx, gap;
      op  = $urandom_range(0, 2);
      idx = $urandom_range(0, 63);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
      issue(op != 0, op != 1, BASE + 4 * idx, $urandom);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
